// File: rtl/decoder_sweep_ctrl.sv
// decoder_sweep_ctrl: walks a decoder select through all values with a gated enable dwell per value
module decoder_sweep_ctrl #(
  parameter int unsigned SEL_WIDTH = 1,
  parameter int unsigned DWELL = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hold,
  output logic [SEL_WIDTH-1:0] sel,
  output logic                 enable,
  output logic                 busy,
  output logic                 done
);
  localparam int unsigned CW = $clog2(DWELL + 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // next state: dwell counting in ACTIVE, one gap cycle between values, sel wraps only when leaving DONE
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ACTIVE;
        sel_d = '0;
        cnt_d = '0;
      end
      ACTIVE: if (!hold) begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(DWELL - 1)) begin
          state_d = &sel_q ? DONE : GAP;
          cnt_d = '0;
        end
      end
      GAP: begin
        state_d = ACTIVE;
        sel_d = sel_q + SEL_WIDTH'(1);
        cnt_d = '0;
      end
      default: begin
        state_d = IDLE;
        sel_d = '0;
      end
    endcase
  end
  // state, select and dwell counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end
  assign sel = sel_q;
  assign enable = (state_q == ACTIVE) && !hold;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule

// File: tb/tb_decoder_sweep_ctrl.sv
// tb_decoder_sweep_ctrl: random and scenario stimulus checked against a sweep-progress model
module tb_decoder_sweep_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, hold = 1'b0;
  logic [0:0] sel0;
  logic [1:0] sel1;
  logic en0, en1, busy0, busy1, done0, done1;
  int n_chk = 0, n_pass = 0;
  int dw [2] = '{4, 1};
  int nn [2] = '{2, 4};
  bit run [2] = '{0, 0};
  int p [2] = '{0, 0};
  always #5 clk = ~clk;
  decoder_sweep_ctrl #(.SEL_WIDTH(1), .DWELL(4)) u0 (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .sel(sel0), .enable(en0), .busy(busy0), .done(done0));
  decoder_sweep_ctrl #(.SEL_WIDTH(2), .DWELL(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .sel(sel1), .enable(en1), .busy(busy1), .done(done1));
  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic compare(int i, int s, int e, int b, int d);
    int ph = p[i] % (dw[i] + 1);
    int last = nn[i] * (dw[i] + 1) - 1;
    check($sformatf("u%0d sel", i), s, run[i] ? p[i] / (dw[i] + 1) : 0);
    check($sformatf("u%0d enable", i), e, int'(run[i] && ph < dw[i] && !hold));
    check($sformatf("u%0d busy", i), b, int'(run[i]));
    check($sformatf("u%0d done", i), d, int'(run[i] && p[i] == last));
  endtask
  task automatic advance(int i);
    int ph = p[i] % (dw[i] + 1);
    int last = nn[i] * (dw[i] + 1) - 1;
    if (reset) begin
      run[i] = 0;
      p[i] = 0;
    end else if (!run[i]) begin
      if (start) begin
        run[i] = 1;
        p[i] = 0;
      end
    end else if (p[i] == last) begin
      run[i] = 0;
      p[i] = 0;
    end else if (!(ph < dw[i] && hold)) begin
      p[i]++;
    end
  endtask
  task automatic step(bit r, bit s, bit h);
    reset = r;
    start = s;
    hold = h;
    @(negedge clk);
    compare(0, int'(sel0), int'(en0), int'(busy0), int'(done0));
    compare(1, int'(sel1), int'(en1), int'(busy1), int'(done1));
    @(posedge clk);
    advance(0);
    advance(1);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    step(0, 1, 0);
    repeat (12) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    repeat (2) step(0, 0, 1);
    repeat (12) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (6) step(0, 0, 0);
    step(0, 1, 0);
    repeat (6) step(0, 0, 0);
    step(0, 1, 0);
    repeat (6) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (12) step(0, 0, 0);
    repeat (40) step(0, 1, 0);
    repeat (1500) step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    repeat (300) step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/decoder_sweep_ctrl.md
# decoder_sweep_ctrl

Sequencer that sits directly upstream of the 1-to-2 / N-way decoder stage and drives its `in` (select) and `enable` inputs. On a start pulse it walks the select value from 0 to 2^SEL_WIDTH−1. It asserts enable for a fixed dwell per value, with one enable-low gap cycle between values (break-before-make), then pulses done. The block lets lab decoders be exercised on the board or in simulation without manual switch toggling.

## Interface
- SEL_WIDTH, 1, select width; decoder has N = 2^SEL_WIDTH outputs.
- DWELL, 4, cycles enable is high per select value; legal range 1..255.

- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; one clock, synchronous reset active-high.
- start  input  1  request a sweep; sampled only in IDLE.
- hold  input  1  pause; freezes dwell counting while in ACTIVE.
- sel  output  SEL_WIDTH  select value to decoder `in`.
- enable  output  1  decoder enable.
- busy  output  1  high from first ACTIVE cycle through DONE cycle.
- done  output  1  one-cycle pulse at end of sweep.

## Operation
- States: IDLE, ACTIVE, GAP, DONE. State, sel and dwell counter are registered. The counter width is the minimum needed to hold DWELL.
- IDLE: sel=0, enable=0, busy=0, done=0. start=1 → ACTIVE, sel=0, count=0.
- ACTIVE: busy=1. enable = ~hold, combinational from the registered state. hold=0: count increments; when count reaches DWELL−1 it goes to GAP if sel≠N−1, else to DONE. hold=1: state, count and sel frozen.
- GAP: enable=0, busy=1, sel unchanged. Next edge → ACTIVE with sel+1 and count=0. hold is ignored.
- DONE: enable=0, busy=1, done=1, sel unchanged. Next edge → IDLE with sel=0. hold is ignored.
- start outside IDLE is ignored; it is not queued. start held high in IDLE after DONE begins a new sweep on the next edge.
- sel never wraps mid-sweep. The only wrap, N−1 → 0, happens on DONE → IDLE.
- Reset, including mid-sweep, forces IDLE, sel=0, count=0 on the next edge. Reset has priority over start and hold.

## Timing
- Reset values: sel=0, enable=0, busy=0, done=0.
- Latency: start sampled high at edge k puts the block in ACTIVE with sel=0 and enable=1 in cycle k+1.
- Enable-high cycles per sel value = exactly DWELL, regardless of hold insertions.
- Sweep length with no hold = N·(DWELL+1) cycles of busy:
  - N dwell windows,
  - N−1 gap cycles,
  - 1 DONE cycle.
- Each hold cycle during ACTIVE extends the sweep by one cycle.
- sel changes only on the edge entering ACTIVE from GAP, or entering IDLE from DONE. It is therefore stable whenever enable=1.
- enable and done are never high in the same cycle.

## Test plan
- Reset then idle: reset=1 for 2 cycles, start=0 → sel=0, enable=0, busy=0, done=0 held for 10 cycles.
- Basic sweep, SEL_WIDTH=1, DWELL=4: start pulse at edge 0 → expected outputs by cycle:
  - cycles 1–4: enable=1, sel=0.
  - cycle 5: enable=0, sel=0.
  - cycles 6–9: enable=1, sel=1.
  - cycle 10: done=1, enable=0.
  - cycle 11: busy=0, sel=0.
- Hold insertion: same config, hold=1 during cycles 2–3 → enable=0 in cycles 2–3. sel=0 enable-high total is still 4 cycles (cycles 1, 4, 5, 6). done is at cycle 12.
- Start while busy: extra start pulses at cycles 3 and 10 → no change to the sequence above. No second sweep begins after cycle 11.
- Reset mid-sweep: reset=1 in cycle 7 (sel=1, enable=1) → cycle 8: IDLE, sel=0, enable=0, busy=0, no done pulse. A start in cycle 9 gives a fresh sweep beginning with sel=0 at cycle 10.
- Wide sweep, SEL_WIDTH=2, DWELL=1, start held high continuously:
  - sel sequence 0,G,1,G,2,G,3 with enable high one cycle each (G = gap cycle, enable=0), then done.
  - One IDLE cycle with busy=0, then the next sweep starts. That gives a period of 9 cycles.
